// File: rtl/bridge_reg_bank_if.sv
// Bridge-side register access bus for bridge_reg_bank.
//
// Handshake: bridge_wr and bridge_rd are single-cycle strobes qualified by
// bridge_addr (and bridge_wr_data for writes). There is no back-pressure.
// Every strobe is accepted on the clock edge where it is high. For a read,
// bridge_rd_data is valid one cycle after the strobe and holds until the
// next read. Strobes may be issued on consecutive cycles.
//
// Signals:
//   bridge_addr     byte address (bits [1:0] ignored by the bank)
//   bridge_wr       write strobe
//   bridge_wr_data  write data
//   bridge_rd       read strobe
//   bridge_rd_data  registered read data (driven by the bank)
interface bridge_reg_bank_if;
  logic [31:0] bridge_addr;
  logic        bridge_wr;
  logic [31:0] bridge_wr_data;
  logic        bridge_rd;
  logic [31:0] bridge_rd_data;

  modport master (
    output bridge_addr,
    output bridge_wr,
    output bridge_wr_data,
    output bridge_rd,
    input  bridge_rd_data
  );

  modport slave (
    input  bridge_addr,
    input  bridge_wr,
    input  bridge_wr_data,
    input  bridge_rd,
    output bridge_rd_data
  );
endinterface

// File: rtl/bridge_reg_bank.sv
// Bank of host-writable 32-bit configuration registers on one bridge leaf.
//
// Each register keeps a shadow copy (what the host wrote, and what reads
// return) and a live copy (what the core sees on regs_out). In immediate
// mode the live copy follows every write. In commit mode the host arms a
// commit through the CTRL word and all live copies update together on the
// next frame_sync, or at once when the host forces a commit.
//
// Ports:
//   clk_74a         single clock, bridge domain
//   reset_n         synchronous active-low reset
//   bridge          register access bus (slave side)
//   frame_sync      one-cycle frame boundary pulse (commit mode only)
//   regs_out        live register values
//   reg_changed     one-cycle pulse per register whose live value changed
//   commit_pending  a commit is armed and waiting for frame_sync
//
// Address map: register i at BASE_ADDR + 4*i, CTRL at BASE_ADDR + 4*NUM_REGS.
// CTRL (commit mode): bit0 arm/cancel, bit1 force commit; reads back
// {30'b0, 1'b0, commit_pending}. In immediate mode CTRL reads 0.
module bridge_reg_bank #(
  parameter int                         NUM_REGS     = 4,
  parameter logic [31:0]                BASE_ADDR    = 32'h0010_0000,
  parameter logic [NUM_REGS-1:0][31:0]  RESET_VALUES = '0,
  parameter logic [NUM_REGS-1:0][31:0]  WRITE_MASK   = '1,
  parameter bit                         COMMIT_MODE  = 1'b0
) (
  input  logic                         clk_74a,
  input  logic                         reset_n,
  bridge_reg_bank_if.slave             bridge,
  input  logic                         frame_sync,
  output logic [NUM_REGS-1:0][31:0]    regs_out,
  output logic [NUM_REGS-1:0]          reg_changed,
  output logic                         commit_pending
);

  localparam logic [29:0] BASE_IDX = BASE_ADDR[31:2];
  localparam logic [29:0] CTRL_IDX = 30'(NUM_REGS);

  logic [NUM_REGS-1:0][31:0] shadow;
  logic [NUM_REGS-1:0][31:0] shadow_next;
  logic [NUM_REGS-1:0][31:0] live;
  logic [NUM_REGS-1:0][31:0] live_next;
  logic [NUM_REGS-1:0]       changed_next;
  logic [29:0]               word_idx;
  logic                      ctrl_wr;
  logic                      force_commit;
  logic                      do_commit;
  logic                      pending_next;
  logic [31:0]               rd_value;
  logic [31:0]               rd_data;
  logic                      unused_addr_bits;

  // Word index relative to the bank. Addresses below BASE_ADDR wrap to a
  // large index and therefore fall out of range.
  assign word_idx         = bridge.bridge_addr[31:2] - BASE_IDX;
  assign unused_addr_bits = ^bridge.bridge_addr[1:0];

  assign ctrl_wr      = COMMIT_MODE && bridge.bridge_wr && (word_idx == CTRL_IDX);
  assign force_commit = ctrl_wr && bridge.bridge_wr_data[1];
  // Both commit sources look at the state before the edge, so a register
  // written in the same cycle stays in shadow for the following commit.
  assign do_commit    = force_commit || (commit_pending && frame_sync);

  always_comb begin
    shadow_next = shadow;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bridge.bridge_wr && (word_idx == 30'(i))) begin
        shadow_next[i] = (shadow[i] & ~WRITE_MASK[i]) |
                         (bridge.bridge_wr_data & WRITE_MASK[i]);
      end
    end
  end

  always_comb begin
    live_next = live;
    if (!COMMIT_MODE) begin
      live_next = shadow_next;
    end else if (do_commit) begin
      live_next = shadow;
    end
  end

  always_comb begin
    changed_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      changed_next[i] = (live_next[i] != live[i]);
    end
  end

  // A CTRL write decides the new pending state; a frame commit without a
  // CTRL write simply clears it. Cancel together with frame_sync therefore
  // still commits (do_commit uses the old pending) and ends at 0.
  always_comb begin
    pending_next = commit_pending;
    if (!COMMIT_MODE) begin
      pending_next = 1'b0;
    end else if (force_commit) begin
      pending_next = 1'b0;
    end else if (ctrl_wr) begin
      pending_next = bridge.bridge_wr_data[0];
    end else if (do_commit) begin
      pending_next = 1'b0;
    end
  end

  // Reads see the shadow before any same-cycle write.
  always_comb begin
    rd_value = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (word_idx == 30'(i)) begin
        rd_value = shadow[i];
      end
    end
    if (word_idx == CTRL_IDX) begin
      rd_value = {31'b0, commit_pending};
    end
  end

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      shadow         <= RESET_VALUES;
      live           <= RESET_VALUES;
      reg_changed    <= '0;
      commit_pending <= 1'b0;
      rd_data        <= '0;
    end else begin
      shadow         <= shadow_next;
      live           <= live_next;
      reg_changed    <= changed_next;
      commit_pending <= pending_next;
      if (bridge.bridge_rd) begin
        rd_data <= rd_value;
      end
    end
  end

  assign regs_out              = live;
  assign bridge.bridge_rd_data = rd_data;

endmodule
